// File: rtl/nave_pkg.sv
// Shared lane encoding for the player-ship position FSMs.
package nave_pkg;

    typedef enum logic [1:0] {
        LANE_L = 2'b00,
        LANE_C = 2'b01,
        LANE_R = 2'b10,
        LANE_X = 2'b11  // never reached by legal moves; decodes to no lane
    } lane_t;

endpackage

// File: rtl/nave_lane_decoder.sv
// One-hot lane decode of the ship position, shared with the renderer.
module nave_lane_decoder
    import nave_pkg::*;
(
    input  lane_t i_sp,
    output logic  o_l,
    output logic  o_c,
    output logic  o_r
);

    always_comb begin
        o_l = (i_sp == LANE_L);
        o_c = (i_sp == LANE_C);
        o_r = (i_sp == LANE_R);
    end

endmodule

// File: rtl/fsm_nave_1.sv
// Lane position FSM for player ship 1: saturating left/right steps, one per clock.
module fsm_nave_1
    import nave_pkg::*;
#(
    parameter lane_t RESET_POS = LANE_C
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_left,
    input  logic       i_right,
    output logic       o_l,
    output logic       o_c,
    output logic       o_r,
    output logic [1:0] o_sp,
    output logic [1:0] o_sfp
);

    lane_t r_sp;
    lane_t w_sfp;
    logic  w_go_left;
    logic  w_go_right;

    // Both buttons pressed cancel out and hold the lane.
    assign w_go_left  = i_left & ~i_right;
    assign w_go_right = i_right & ~i_left;

    always_comb begin
        w_sfp = LANE_C;
        case (r_sp)
            LANE_L:  w_sfp = w_go_right ? LANE_C : LANE_L;
            LANE_C: begin
                if (w_go_left) begin
                    w_sfp = LANE_L;
                end else if (w_go_right) begin
                    w_sfp = LANE_R;
                end else begin
                    w_sfp = LANE_C;
                end
            end
            LANE_R:  w_sfp = w_go_left ? LANE_C : LANE_R;
            default: w_sfp = LANE_C;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sp <= RESET_POS;
        end else begin
            r_sp <= w_sfp;
        end
    end

    assign o_sp  = r_sp;
    assign o_sfp = w_sfp;

    nave_lane_decoder u_decoder (
        .i_sp (r_sp),
        .o_l  (o_l),
        .o_c  (o_c),
        .o_r  (o_r)
    );

endmodule

// File: tb/tb_fsm_nave_1.sv
// Bench for fsm_nave_1: directed corner cases then random buttons against a lane-index model.
module tb_fsm_nave_1;
    import nave_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       left;
    logic       right;
    logic       o_l;
    logic       o_c;
    logic       o_r;
    logic [1:0] o_sp;
    logic [1:0] o_sfp;

    int total = 0;
    int bad   = 0;
    int pos   = 1;
    bit known = 0;

    fsm_nave_1 dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_left  (left),
        .i_right (right),
        .o_l     (o_l),
        .o_c     (o_c),
        .o_r     (o_r),
        .o_sp    (o_sp),
        .o_sfp   (o_sfp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Lane index 0=left, 1=centre, 2=right; moves clamp at the edges.
    function automatic int model_next(input int p, input bit l, input bit r);
        int n;
        n = p;
        if (l && !r) n = p - 1;
        if (r && !l) n = p + 1;
        if (n < 0) n = 0;
        if (n > 2) n = 2;
        return n;
    endfunction

    function automatic int model_lcr(input int p);
        return 4 >> p;
    endfunction

    task automatic step(input bit rn, input bit l, input bit r);
        @(negedge clk);
        rst_n = rn;
        left  = l;
        right = r;
        #1;
        if (known) chk("sfp", int'(o_sfp), model_next(pos, l, r));
        @(posedge clk);
        pos   = rn ? model_next(pos, l, r) : 1;
        known = 1;
        #1;
        chk("sp", int'(o_sp), pos);
        chk("lcr", int'({o_l, o_c, o_r}), model_lcr(pos));
    endtask

    initial begin
        rst_n = 1'b1;
        left  = 1'b0;
        right = 1'b0;

        // Reset with LEFT held: reset wins, next state already points left.
        step(1'b0, 1'b1, 1'b0);
        chk("rst_sfp", int'(o_sfp), 0);

        // Right to the edge and saturate.
        repeat (4) step(1'b1, 1'b0, 1'b1);
        // Left to the edge and saturate.
        repeat (3) step(1'b1, 1'b1, 1'b0);

        // Hold with both released and both pressed in every lane.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b1);
            chk("hold_sfp", int'(o_sfp), pos);
            if (k < 2) step(1'b1, 1'b0, 1'b1);
        end

        // Illegal state: no lane lit, next state recovers to centre.
        step(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        force dut.r_sp = LANE_X;
        for (int c = 0; c < 4; c++) begin
            left  = c[0];
            right = c[1];
            #1;
            chk("ill_lcr", int'({o_l, o_c, o_r}), 0);
            chk("ill_sfp", int'(o_sfp), 1);
        end
        left  = 1'b0;
        right = 1'b0;
        release dut.r_sp;
        @(posedge clk);
        #1;
        pos = 1;
        chk("ill_recover", int'(o_sp), 1);

        // Reset on the same edge as a move request discards the move.
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
